// File: rtl/serial_subtractor_if.sv
// Bus bundle for serial_subtractor: request side (start, a, b) and the
// result side (busy, done, diff, bout and, with SERIAL_SUBTRACTOR_OVF_EN
// defined, ovf). WIDTH must match the WIDTH of the attached subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, bout);
  modport slave  (input start, a, b, output busy, done, diff, bout);
`endif

endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b one bit per clock, LSB first.
// A start in IDLE captures the operands, WIDTH RUN cycles follow, then one
// DONE cycle pulses done. Results hold until the next accepted start.
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN adds the signed
// overflow flag ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] sub_bit(input logic a_i, input logic b_i, input logic br_i);
    logic d;
    logic br;
    d  = a_i ^ b_i ^ br_i;
    br = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);
    return {br, d};
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] a_sh_s;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] b_sh_s;
  logic [WIDTH-1:0] diff_r;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH:0]   diff_cat_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             br_r;
  logic             br_s;
  logic             bout_r;
  logic             bout_s;
  logic             busy_r;
  logic             done_r;
  logic [1:0]       cell_s;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf_r;
  logic             ovf_s;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath next values; the shift registers hold bit 0 of
  // the operands, so on the last RUN cycle they hold the original MSBs.
  always_comb begin
    state_s    = state_r;
    a_sh_s     = a_sh_r;
    b_sh_s     = b_sh_r;
    diff_s     = diff_r;
    cnt_s      = cnt_r;
    br_s       = br_r;
    bout_s     = bout_r;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ovf_s      = ovf_r;
`endif
    cell_s     = sub_bit(a_sh_r[0], b_sh_r[0], br_r);
    diff_cat_s = {cell_s[0], diff_r};
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = RUN;
          a_sh_s  = bus.a;
          b_sh_s  = bus.b;
          br_s    = 1'b0;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        diff_s = diff_cat_s[WIDTH:1];
        a_sh_s = a_sh_r >> 1;
        b_sh_s = b_sh_r >> 1;
        br_s   = cell_s[1];
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
          bout_s  = cell_s[1];
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf_s   = (a_sh_r[0] != b_sh_r[0]) && (cell_s[0] != a_sh_r[0]);
`endif
        end else begin
          state_s = RUN;
          cnt_s   = cnt_r + CNT_W'(1'b1);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Datapath and registered status outputs (busy/done track the next state
  // so they are high exactly while the state register is RUN/DONE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r <= {WIDTH{1'b0}};
      b_sh_r <= {WIDTH{1'b0}};
      diff_r <= {WIDTH{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      br_r   <= 1'b0;
      bout_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      a_sh_r <= a_sh_s;
      b_sh_r <= b_sh_s;
      diff_r <= diff_s;
      cnt_r  <= cnt_s;
      br_r   <= br_s;
      bout_r <= bout_s;
      busy_r <= (state_s == RUN);
      done_r <= (state_s == DONE);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_r  <= ovf_s;
`endif
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign bus.ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed table,
// randomized operands against an arithmetic reference, and hand-written
// sequences for start-during-RUN, reset-during-RUN and back-to-back starts.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_subtractor_if #(.WIDTH(W)) bus_if ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {ovf, bout, diff} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int ux, uy, sx, sy, r;
    logic [W-1:0] d;
    logic bo, ov;
    ux = int'(x);
    uy = int'(y);
    d  = W'(ux - uy + (1 << W));
    bo = (ux < uy);
    sx = x[W-1] ? ux - (1 << W) : ux;
    sy = y[W-1] ? uy - (1 << W) : uy;
    r  = sx - sy;
    ov = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    return {ov, bo, d};
  endfunction

  task automatic chk_ovf(input string name, input logic exp);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk(name, {31'd0, bus_if.ovf}, {31'd0, exp});
`endif
  endtask

  // One full operation from IDLE; operands are scrambled after acceptance.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int lat;
    logic [W-1:0] held;
    lat = 0;
    bus_if.start = 1'b1;
    bus_if.a     = ta;
    bus_if.b     = tb_v;
    tick();
    bus_if.start = 1'b0;
    bus_if.a     = W'($urandom);
    bus_if.b     = W'($urandom);
    for (int k = 1; k <= W + 4; k++) begin
      tick();
      if (bus_if.busy && bus_if.done) chk({name, "_busy_and_done"}, 32'd1, 32'd0);
      if (bus_if.done) begin
        lat = k;
        break;
      end
    end
    chk({name, "_latency"}, lat, W);
    chk({name, "_diff"}, bus_if.diff, ed);
    chk({name, "_bout"}, bus_if.bout, eb);
    chk_ovf({name, "_ovf"}, eo);
    held = bus_if.diff;
    tick();
    chk({name, "_done_pulse"}, {bus_if.busy, bus_if.done}, 2'b00);
    chk({name, "_diff_hold"}, bus_if.diff, held);
  endtask

  vec_t vecs[6];

  initial begin
    logic [W+1:0] m;
    logic [W-1:0] ra, rb;
    int busy_cnt, lat, idx, lowcnt;
    int done_cyc[3];
    int cyc;
    logic [W-1:0] opa[3];
    logic [W-1:0] opb[3];

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus_if.start = 1'b0;
    bus_if.a = '0;
    bus_if.b = '0;

    vecs[0] = '{a: 8'h05, b: 8'h03, diff: 8'h02, bout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, bout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, bout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, diff: 8'h00, bout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, bout: 1'b0, ovf: 1'b1};
    vecs[5] = '{a: 8'h7F, b: 8'hFF, diff: 8'h80, bout: 1'b1, ovf: 1'b1};

    // Reset state.
    #22;
    chk("reset_outputs", {bus_if.busy, bus_if.done, bus_if.bout, bus_if.diff}, '0);
    chk_ovf("reset_ovf", 1'b0);
    tick();
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout, vecs[i].ovf);
    end

    // Randomized operands against the reference.
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      m  = model(ra, rb);
      run_op($sformatf("rand%0d", i), ra, rb, m[W-1:0], m[W], m[W+1]);
    end

    // Start during RUN is ignored and busy lasts exactly W cycles.
    bus_if.start = 1'b1;
    bus_if.a = 8'h10;
    bus_if.b = 8'h01;
    tick();
    bus_if.start = 1'b0;
    busy_cnt = bus_if.busy ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= W + 4; k++) begin
      if (k == 3) begin
        bus_if.start = 1'b1;
        bus_if.a = 8'hAA;
        bus_if.b = 8'h55;
      end
      tick();
      bus_if.start = 1'b0;
      if (bus_if.busy) busy_cnt++;
      if (bus_if.done) begin
        lat = k;
        break;
      end
    end
    chk("ign_latency", lat, W);
    chk("ign_busy_cycles", busy_cnt, W);
    chk("ign_diff", bus_if.diff, 8'h0F);
    chk("ign_bout", bus_if.bout, 1'b0);
    tick();
    tick();
    tick();
    chk("ign_no_second_op", {bus_if.busy, bus_if.done}, 2'b00);

    // Reset during RUN abandons the operation.
    bus_if.start = 1'b1;
    bus_if.a = 8'h33;
    bus_if.b = 8'h11;
    tick();
    bus_if.start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_run_outputs", {bus_if.busy, bus_if.done, bus_if.bout, bus_if.diff}, '0);
    chk_ovf("rst_run_ovf", 1'b0);
    lat = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (bus_if.done || bus_if.busy) lat++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      tick();
      if (bus_if.done || bus_if.busy) lat++;
    end
    chk("rst_no_done", lat, 0);
    run_op("post_rst", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

    // Back-to-back with start held high.
    opa[0] = 8'h20; opb[0] = 8'h07;
    opa[1] = 8'h01; opb[1] = 8'h02;
    opa[2] = 8'hC3; opb[2] = 8'h3C;
    idx = 0;
    lowcnt = 0;
    cyc = 0;
    bus_if.start = 1'b1;
    bus_if.a = opa[0];
    bus_if.b = opb[0];
    for (int k = 0; k < 60 && idx < 3; k++) begin
      tick();
      cyc++;
      if (bus_if.busy && bus_if.done) chk("b2b_busy_and_done", 32'd1, 32'd0);
      if (idx >= 1 && !bus_if.busy) lowcnt++;
      if (bus_if.done) begin
        m = model(opa[idx], opb[idx]);
        chk($sformatf("b2b_diff%0d", idx), bus_if.diff, m[W-1:0]);
        chk($sformatf("b2b_bout%0d", idx), bus_if.bout, m[W]);
        done_cyc[idx] = cyc;
        idx++;
        if (idx < 3) begin
          bus_if.a = opa[idx];
          bus_if.b = opb[idx];
        end else begin
          bus_if.start = 1'b0;
        end
      end
    end
    bus_if.start = 1'b0;
    chk("b2b_ops_done", idx, 3);
    if (idx == 3) begin
      chk("b2b_gap1", done_cyc[1] - done_cyc[0], W + 2);
      chk("b2b_gap2", done_cyc[2] - done_cyc[1], W + 2);
      chk("b2b_busy_low", lowcnt, 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; legal range 1..32.
REQ-002 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port start  input  1  request to begin a subtraction; sampled on the rising edge of clk.
REQ-005 Port a  input  WIDTH  minuend; captured when start is accepted.
REQ-006 Port b  input  WIDTH  subtrahend; captured when start is accepted.
REQ-007 Port busy  output  1  high while an operation is in progress (state RUN).
REQ-008 Port done  output  1  single-cycle pulse marking a valid diff and bout.
REQ-009 Port diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-010 Port bout  output  1  final borrow; 1 when a<b unsigned.
REQ-011 Port ovf  output  1  signed overflow flag; present only when the Configuration macro is defined.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL, at that edge, capture a and b into shift registers, clear the borrow flop, load the bit counter with 0 and enter RUN.
REQ-014 In RUN, each edge SHALL process one bit LSB-first: d=a0^b0^br; br_next=(~a0&b0)|(~(a0^b0)&br); shift d into diff from the MSB end; shift a and b right by one.
REQ-015 RUN SHALL last exactly WIDTH edges; on the WIDTH-th RUN edge the state SHALL go to DONE and bout SHALL take the final br_next.
REQ-016 done SHALL be high for exactly one cycle (state DONE), beginning WIDTH edges after the edge that accepted start; DONE SHALL return to IDLE unconditionally on the next edge.
REQ-017 busy SHALL equal 1 only in RUN; done SHALL equal 1 only in DONE; busy and done SHALL never be high together.
REQ-018 start SHALL be ignored in RUN and DONE, and the in-flight operands SHALL be unaffected by changes on a and b.
REQ-019 diff and bout SHALL be updated only on RUN edges and SHALL hold their values in DONE and IDLE until the next accepted start.
REQ-020 Back-to-back operation: start held high SHALL be accepted on the first IDLE edge after DONE, giving throughput of one result per WIDTH+2 cycles.
REQ-021 WIDTH=1 SHALL work: one RUN edge, then DONE.

Reset
REQ-022 rst_n=0 SHALL immediately, independent of clk, force state IDLE, counter 0, borrow 0, busy 0, done 0, diff 0, bout 0 and ovf 0.
REQ-023 Reset asserted during RUN SHALL abandon the operation; no done pulse SHALL be produced for it.
REQ-024 After rst_n deasserts, start SHALL be accepted on the first rising edge where it is high.

Configuration
REQ-025 Macro SERIAL_SUBTRACTOR_OVF_EN: when defined, port ovf SHALL exist and be set on the last RUN edge to (aMSB!=bMSB)&&(dMSB!=aMSB), holding like diff; when undefined, port ovf and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-026 WIDTH=8, a=0x05, b=0x03, start pulse -> done 8 edges later, diff=0x02, bout=0, ovf=0.
REQ-027 a=0x03, b=0x05 -> diff=0xFE, bout=1; a=0x00, b=0x01 -> diff=0xFF, bout=1; a=0xFF, b=0xFF -> diff=0x00, bout=0.
REQ-028 With SERIAL_SUBTRACTOR_OVF_EN defined, a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
REQ-029 Start a=0x10, b=0x01, then pulse start with a=0xAA, b=0x55 on RUN edge 3 -> second start ignored; diff=0x0F; busy stays high for 8 cycles.
REQ-030 rst_n driven low on RUN edge 4, released 2 cycles later -> all outputs 0, no done pulse; a new start of 0x09-0x04 -> diff=0x05.
REQ-031 start held high continuously for 3 operations -> done pulses exactly 10 cycles apart; busy is low only in the DONE and IDLE cycle between operations.
